mac_neuron: RTL and testbench

MAC_NEURON -- requirements
Module: mac_neuron

---
 rtl/mac_neuron_pkg.sv | 22 ++
 rtl/mac_neuron_sm_mult.sv | 57 +++++
 rtl/mac_neuron.sv | 119 +++++++++++
 tb/tb_mac_neuron.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_neuron_pkg.sv
// mac_neuron_pkg: shared state encoding, default parameter values and the
// counter-width helper for the MAC neuron slice.
// Optional build macro used by this slice: MAC_NEURON_SAT_EN (saturating accumulation).
package mac_neuron_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int N_IN_DEF   = 10;
    localparam int ACC_W_DEF  = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ACT   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter must be able to hold the value N_IN itself.
    function automatic int cntWidth(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mac_neuron_sm_mult.sv
// sm_mult: combinational sign-magnitude multiplier producing an ACC_W-bit
// two's-complement product. Negative zero (zero magnitude with sign set) gives 0.
// With MAC_NEURON_SAT_EN defined, a product too large for ACC_W bits is clamped
// so that the saturating accumulator sees the correct direction of overflow;
// otherwise the product is taken modulo 2^ACC_W, which matches wrap-around accumulation.
module sm_mult
    import mac_neuron_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  p
);

    localparam int MAG_W = DATA_W - 1;
    localparam int PRD_W = 2 * MAG_W;

    logic [MAG_W-1:0] magA;
    logic [MAG_W-1:0] magB;
    logic             negProd;

    assign magA    = a[DATA_W-2:0];
    assign magB    = b[DATA_W-2:0];
    assign negProd = (a[DATA_W-1] ^ b[DATA_W-1]) && (|magA) && (|magB);

`ifdef MAC_NEURON_SAT_EN
    localparam int WIDE_W = ((PRD_W > ACC_W) ? PRD_W : ACC_W) + 2;

    logic [PRD_W-1:0]  magProd;
    logic [WIDE_W-1:0] magWide;
    logic [WIDE_W-1:0] sWide;

    assign magProd = magA * magB;
    assign magWide = WIDE_W'(magProd);
    assign sWide   = negProd ? (~magWide + WIDE_W'(1)) : magWide;

    // Clamp the full-precision signed product into the ACC_W range.
    always_comb begin
        p = sWide[ACC_W-1:0];
        if (!((&sWide[WIDE_W-1:ACC_W-1]) || ~(|sWide[WIDE_W-1:ACC_W-1]))) begin
            p = sWide[WIDE_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    logic [ACC_W-1:0] magTrunc;

    assign magTrunc = ACC_W'(magA) * ACC_W'(magB);

    // Modular conversion: two's-complement negate of the truncated magnitude.
    always_comb begin
        p = negProd ? (~magTrunc + ACC_W'(1)) : magTrunc;
    end
`endif

endmodule

// File: rtl/mac_neuron.sv
// mac_neuron: sequential multiply-accumulate neuron with ReLU output.
// IDLE waits for start, ACCUM takes N_IN x*w terms, ACT applies ReLU,
// DONE presents y until the consumer takes it.
// Optional build macro: MAC_NEURON_SAT_EN selects saturating accumulation
// instead of wrap-around.
module mac_neuron
    import mac_neuron_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_IN   = N_IN_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  y,
    output logic              busy
);

    localparam int CNT_W = cntWidth(N_IN);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] y_q, y_d;
    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] accSum;

    sm_mult #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mult (
        .a(x),
        .b(w),
        .p(prod)
    );

`ifdef MAC_NEURON_SAT_EN
    logic [ACC_W:0] sumWide;

    assign sumWide = {acc_q[ACC_W-1], acc_q} + {prod[ACC_W-1], prod};

    // Saturating add: the two top bits disagree only on overflow/underflow.
    always_comb begin
        accSum = sumWide[ACC_W-1:0];
        if (sumWide[ACC_W] != sumWide[ACC_W-1]) begin
            accSum = sumWide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    // Plain modular add.
    always_comb begin
        accSum = acc_q + prod;
    end
`endif

    // Next-state logic: sequencing, accumulation, term counting and ReLU load.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = accSum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_IN - 1)) begin
                        state_d = ACT;
                    end
                end
            end
            ACT: begin
                y_d     = acc_q[ACC_W-1] ? '0 : acc_q;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous active-low clear of all datapath state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign y         = y_q;

endmodule

// File: tb/tb_mac_neuron.sv
// tb_mac_neuron: table-driven directed test of mac_neuron, with a second
// ACC_W=12 instance driven in lockstep to exercise overflow behaviour.
// Build macro honoured: MAC_NEURON_SAT_EN.
module tb_mac_neuron;

    logic        clk;
    logic        rst;
    logic        start;
    logic        inValid;
    logic [7:0]  x;
    logic [7:0]  w;
    logic        outReady;
    logic        inReady;
    logic        outValid;
    logic [19:0] y;
    logic        busy;
    logic        inReady12;
    logic        outValid12;
    logic [11:0] y12;
    logic        busy12;

    int assertCount;
    int failCount;

`ifdef MAC_NEURON_SAT_EN
    localparam int Y12_BIG = 2047;
`else
    localparam int Y12_BIG = 1546;
`endif

    typedef struct {
        logic [7:0] x1;
        logic [7:0] w1;
        int         split;
        logic [7:0] x2;
        logic [7:0] w2;
        int         expAcc;
        int         expY;
        int         expY12;
        bit         gap;
        bit         hold;
    } vec_t;

    vec_t vecs[9];

    mac_neuron dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (inValid),
        .in_ready (inReady),
        .x        (x),
        .w        (w),
        .out_valid(outValid),
        .out_ready(outReady),
        .y        (y),
        .busy     (busy)
    );

    mac_neuron #(.ACC_W(12)) dut12 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (inValid),
        .in_ready (inReady12),
        .x        (x),
        .w        (w),
        .out_valid(outValid12),
        .out_ready(outReady),
        .y        (y12),
        .busy     (busy12)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One complete evaluation for table entry idx on both instances.
    task automatic applyStimulus(input int idx);
        vec_t v;
        int   yHold;
        v = vecs[idx];
        @(negedge clk);
        inValid = 1'b1;
        x = 8'h7F;
        w = 8'h7F;
        @(negedge clk);
        checkOutput("idle_invalid_busy", int'(busy), 0);
        checkOutput("idle_in_ready", int'(inReady), 0);
        inValid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("accum_in_ready", int'(inReady), 1);
        checkOutput("accum_busy", int'(busy), 1);
        for (int k = 0; k < 10; k++) begin
            if (v.gap && (k % 3 == 1)) begin
                inValid = 1'b0;
                x = 8'h7F;
                w = 8'h7F;
                @(negedge clk);
            end
            inValid = 1'b1;
            x = (k < v.split) ? v.x1 : v.x2;
            w = (k < v.split) ? v.w1 : v.w2;
            @(negedge clk);
        end
        // Now one edge past the last accept: ACT, term N_IN+1 offered and must be ignored.
        x = 8'h7F;
        w = 8'h7F;
        checkOutput("act_out_valid", int'(outValid), 0);
        checkOutput("act_in_ready", int'(inReady), 0);
        checkOutput("act_busy", int'(busy), 1);
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("done_out_valid", int'(outValid), 1);
        checkOutput("done_y", int'(y), v.expY);
        checkOutput("done_y12", int'(y12), v.expY12);
        checkOutput("done_acc", int'($signed(dut.acc_q)), v.expAcc);
        if (v.hold) begin
            yHold = int'(y);
            for (int i = 0; i < 5; i++) begin
                start = (i == 2);
                @(negedge clk);
                checkOutput("hold_out_valid", int'(outValid), 1);
                checkOutput("hold_y", int'(y), yHold);
            end
        end
        outReady = 1'b1;
        start = v.hold;
        @(negedge clk);
        outReady = 1'b0;
        start = 1'b0;
        checkOutput("after_ack_out_valid", int'(outValid), 0);
        checkOutput("after_ack_busy", int'(busy), 0);
        @(negedge clk);
        checkOutput("after_ack_still_idle", int'(busy), 0);
    endtask

    // Main sequence: reset, table of evaluations, then mid-run abort by reset.
    initial begin
        assertCount = 0;
        failCount   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        inValid  = 1'b0;
        x        = '0;
        w        = '0;
        outReady = 1'b0;

        vecs[0] = '{8'h05, 8'h03, 10, 8'h00, 8'h00, 150, 150, 150, 1'b0, 1'b0};
        vecs[1] = '{8'h85, 8'h03, 10, 8'h00, 8'h00, -150, 0, 0, 1'b0, 1'b0};
        vecs[2] = '{8'h05, 8'h03, 5, 8'h85, 8'h02, 25, 25, 25, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h7F, 1, 8'h05, 8'h03, 135, 135, 135, 1'b0, 1'b0};
        vecs[4] = '{8'h83, 8'h04, 3, 8'h02, 8'h05, 34, 34, 34, 1'b0, 1'b0};
        vecs[5] = '{8'h05, 8'h03, 10, 8'h00, 8'h00, 150, 150, 150, 1'b1, 1'b1};
        vecs[6] = '{8'h7F, 8'h7F, 10, 8'h00, 8'h00, 161290, 161290, Y12_BIG, 1'b0, 1'b0};
        vecs[7] = '{8'h7F, 8'hFF, 10, 8'h00, 8'h00, -161290, 0, 0, 1'b0, 1'b0};
        vecs[8] = '{8'h81, 8'h81, 10, 8'h00, 8'h00, 10, 10, 10, 1'b0, 1'b0};

        #12;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_in_ready", int'(inReady), 0);
        checkOutput("reset_out_valid", int'(outValid), 0);
        checkOutput("reset_y", int'(y), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_reset_idle", int'(busy), 0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(i);
        end

        // Abort a run after four accepted terms with an asynchronous reset.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            inValid = 1'b1;
            x = 8'h7F;
            w = 8'h7F;
            @(negedge clk);
        end
        inValid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_in_ready", int'(inReady), 0);
        checkOutput("abort_out_valid", int'(outValid), 0);
        checkOutput("abort_y", int'(y), 0);
        checkOutput("abort_y12", int'(y12), 0);
        checkOutput("abort_acc", int'($signed(dut.acc_q)), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("abort_stays_idle", int'(busy), 0);
        applyStimulus(0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
